// File: rtl/nor_pair_checker_pkg.sv
// Shared types and the reference NOR-pair function for the NOR bank checker.
package nor_pair_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Output bit order of the bank does not follow operand order; keep this mapping in one place.
  function automatic logic [3:0] nor_pair_expect(input logic [7:0] a);
    logic [3:0] e;
    e[0] = ~(a[0] | a[1]);
    e[1] = ~(a[6] | a[7]);
    e[2] = ~(a[4] | a[5]);
    e[3] = ~(a[2] | a[3]);
    return e;
  endfunction

endpackage

// File: rtl/nor_pair_checker_if.sv
// Beat handshake between the upstream NOR bank (master) and the checker (slave).
interface nor_pair_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [3:0] in_s;

  modport master (output in_valid, output in_a, output in_s, input in_ready);
  modport slave  (input in_valid, input in_a, input in_s, output in_ready);
endinterface

// File: rtl/nor_pair_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/nor_pair_checker.sv
// Checks NOR-bank beats against the expected NOR pairs and counts passes/fails per run.
// Optional NOR_PAIR_FIRST_ERR_EN adds capture of the first failing beat's operands/results.
module nor_pair_checker
  import nor_pair_pkg::*;
#(
  parameter int NUM_VEC = 256,
  parameter int CNT_W   = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  nor_pair_checker_if.slave   bus,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
`ifdef NOR_PAIR_FIRST_ERR_EN
  output logic [7:0]          first_err_a,
  output logic [3:0]          first_err_s,
`endif
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept_s;
  logic             run_entry_s;
  logic             match_s;
  logic             last_s;
  logic [CNT_W-1:0] beat_cnt_s;

  // busy_q always mirrors state RUN, so it doubles as the acceptance gate.
  assign accept_s    = bus.in_valid & busy_q;
  assign run_entry_s = start & (state_q != RUN);
  assign match_s     = accept_s & (bus.in_s == nor_pair_expect(bus.in_a));
  assign last_s      = accept_s & (beat_cnt_s == CNT_W'(NUM_VEC - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = RUN;  else state_d = IDLE;
      RUN:     if (last_s) state_d = DONE; else state_d = RUN;
      DONE:    if (start)  state_d = RUN;  else state_d = DONE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    if (run_entry_s) begin
      err_d = 1'b0;
    end else if (accept_s && !match_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_beat_cnt (
    .clk (clk), .rst (reset), .clr (run_entry_s), .inc (accept_s), .cnt (beat_cnt_s)
  );

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk (clk), .rst (reset), .clr (run_entry_s), .inc (match_s), .cnt (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk (clk), .rst (reset), .clr (run_entry_s), .inc (accept_s & ~match_s), .cnt (fail_cnt)
  );

`ifdef NOR_PAIR_FIRST_ERR_EN
  logic [7:0] first_err_a_q, first_err_a_d;
  logic [3:0] first_err_s_q, first_err_s_d;

  // Latch operands/results of the first failing beat of a run, while fail_cnt is still zero.
  always_comb begin
    first_err_a_d = first_err_a_q;
    first_err_s_d = first_err_s_q;
    if (run_entry_s) begin
      first_err_a_d = 8'h00;
      first_err_s_d = 4'h0;
    end else if (accept_s && !match_s && (fail_cnt == '0)) begin
      first_err_a_d = bus.in_a;
      first_err_s_d = bus.in_s;
    end else begin
      first_err_a_d = first_err_a_q;
      first_err_s_d = first_err_s_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_err_a_q <= 8'h00;
      first_err_s_q <= 4'h0;
    end else begin
      first_err_a_q <= first_err_a_d;
      first_err_s_q <= first_err_s_d;
    end
  end

  assign first_err_a = first_err_a_q;
  assign first_err_s = first_err_s_q;
`endif

  assign bus.in_ready = busy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_nor_pair_checker.sv
// Randomized bench for nor_pair_checker: a 256-beat and a 4-beat instance share stimulus
// and are each compared every cycle against a run-level behavioural model.
module tb_nor_pair_checker;

  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  nor_pair_checker_if bus0 ();
  nor_pair_checker_if bus4 ();

  logic [8:0] pass0, fail0, pass4, fail4;
  logic       busy0, done0, err0, busy4, done4, err4;
`ifdef NOR_PAIR_FIRST_ERR_EN
  logic [7:0] fea0, fea4;
  logic [3:0] fes0, fes4;
`endif

  nor_pair_checker #(.NUM_VEC(256), .CNT_W(9)) dut0 (
    .clk (clk), .reset (reset), .start (start), .bus (bus0.slave),
    .pass_cnt (pass0), .fail_cnt (fail0),
`ifdef NOR_PAIR_FIRST_ERR_EN
    .first_err_a (fea0), .first_err_s (fes0),
`endif
    .busy (busy0), .done (done0), .err (err0)
  );

  nor_pair_checker #(.NUM_VEC(4), .CNT_W(9)) dut4 (
    .clk (clk), .reset (reset), .start (start), .bus (bus4.slave),
    .pass_cnt (pass4), .fail_cnt (fail4),
`ifdef NOR_PAIR_FIRST_ERR_EN
    .first_err_a (fea4), .first_err_s (fes4),
`endif
    .busy (busy4), .done (done4), .err (err4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Model state per instance: 0 idle, 1 running, 2 finished.
  int         nvec [2] = '{256, 4};
  int         m_st [2];
  int         m_beats [2];
  int         m_pass [2];
  int         m_fail [2];
  logic [7:0] m_fea [2];
  logic [3:0] m_fes [2];
  localparam int CAP = 511;

  function automatic logic [3:0] ref_exp(input logic [7:0] a);
    int lo [4] = '{0, 6, 4, 2};
    logic [3:0] e;
    for (int k = 0; k < 4; k++) e[k] = (a[lo[k]] == 1'b0) && (a[lo[k] + 1] == 1'b0);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_beats[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
      m_fea[i] = 8'h00; m_fes[i] = 4'h0;
    end
  endtask

  task automatic model_step(input logic st, input logic v, input logic [7:0] a, input logic [3:0] s);
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] == 1) begin
        if (v) begin
          m_beats[i]++;
          if (s == ref_exp(a)) begin
            if (m_pass[i] < CAP) m_pass[i]++;
          end else begin
            if (m_fail[i] == 0) begin m_fea[i] = a; m_fes[i] = s; end
            if (m_fail[i] < CAP) m_fail[i]++;
          end
          if (m_beats[i] == nvec[i]) m_st[i] = 2;
        end
      end else if (st) begin
        m_st[i] = 1; m_beats[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
        m_fea[i] = 8'h00; m_fes[i] = 4'h0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/pass0"},  32'(pass0), 32'(m_pass[0]));
    chk({tag, "/fail0"},  32'(fail0), 32'(m_fail[0]));
    chk({tag, "/busy0"},  32'(busy0), 32'(m_st[0] == 1));
    chk({tag, "/rdy0"},   32'(bus0.in_ready), 32'(m_st[0] == 1));
    chk({tag, "/done0"},  32'(done0), 32'(m_st[0] == 2));
    chk({tag, "/err0"},   32'(err0),  32'(m_fail[0] != 0));
    chk({tag, "/pass4"},  32'(pass4), 32'(m_pass[1]));
    chk({tag, "/fail4"},  32'(fail4), 32'(m_fail[1]));
    chk({tag, "/busy4"},  32'(busy4), 32'(m_st[1] == 1));
    chk({tag, "/rdy4"},   32'(bus4.in_ready), 32'(m_st[1] == 1));
    chk({tag, "/done4"},  32'(done4), 32'(m_st[1] == 2));
    chk({tag, "/err4"},   32'(err4),  32'(m_fail[1] != 0));
`ifdef NOR_PAIR_FIRST_ERR_EN
    chk({tag, "/fea0"}, 32'(fea0), 32'(m_fea[0]));
    chk({tag, "/fes0"}, 32'(fes0), 32'(m_fes[0]));
    chk({tag, "/fea4"}, 32'(fea4), 32'(m_fea[1]));
    chk({tag, "/fes4"}, 32'(fes4), 32'(m_fes[1]));
`endif
  endtask

  task automatic cyc(input logic st, input logic v, input logic [7:0] a, input logic [3:0] s,
                     input string tag);
    @(negedge clk);
    start = st;
    bus0.in_valid = v; bus0.in_a = a; bus0.in_s = s;
    bus4.in_valid = v; bus4.in_a = a; bus4.in_s = s;
    @(posedge clk);
    model_step(st, v, a, s);
    #1;
    check_all(tag);
  endtask

  // Random beat: roughly one in four carries a corrupted result.
  task automatic rand_beat(input logic st, input logic v, input string tag);
    logic [7:0] a;
    logic [3:0] s;
    a = 8'($urandom_range(0, 255));
    s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ref_exp(a);
    cyc(st, v, a, s, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    bus0.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int c;
    reset = 1'b1;
    start = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_a = 8'h00; bus0.in_s = 4'h0;
    bus4.in_valid = 1'b0; bus4.in_a = 8'h00; bus4.in_s = 4'h0;
    model_reset();

    // Reset then idle; beats offered in IDLE must not count.
    do_reset("reset");
    for (int i = 0; i < 3; i++) rand_beat(1'b0, 1'b1, "idle");
    chk("idle_ready", 32'(bus0.in_ready), 32'd0);
    chk("idle_pass",  32'(pass0), 32'd0);

    // Exhaustive correct run on the 256-beat instance.
    cyc(1'b1, 1'b0, 8'h00, 4'h0, "start_all");
    for (int i = 0; i < 256; i++) cyc(1'b0, 1'b1, 8'(i), ref_exp(8'(i)), "all");
    chk("all_pass", 32'(pass0), 32'd256);
    chk("all_fail", 32'(fail0), 32'd0);
    chk("all_done", 32'(done0), 32'd1);
    chk("all_err",  32'(err0),  32'd0);
    rand_beat(1'b0, 1'b1, "done_hold");
    chk("done_hold_pass", 32'(pass0), 32'd256);

    // Directed 4-beat run.
    cyc(1'b1, 1'b0, 8'h00, 4'h0, "start4");
    cyc(1'b0, 1'b1, 8'b1101_1000, 4'b0000, "d4");
    cyc(1'b0, 1'b1, 8'h00, 4'hF, "d4");
    cyc(1'b0, 1'b1, 8'hFF, 4'h0, "d4");
    cyc(1'b0, 1'b1, 8'hFF, 4'h0, "d4");
    chk("d4_pass", 32'(pass4), 32'd3);
    chk("d4_fail", 32'(fail4), 32'd1);
    chk("d4_err",  32'(err4),  32'd1);
    chk("d4_done", 32'(done4), 32'd1);
`ifdef NOR_PAIR_FIRST_ERR_EN
    chk("d4_fea", 32'(fea4), 32'hD8);
`endif

    // in_valid toggling every other cycle until the long run completes.
    do_reset("reset_tog");
    cyc(1'b1, 1'b0, 8'h00, 4'h0, "start_tog");
    c = 0;
    while (!done0 && c < 1200) begin
      rand_beat(1'b0, 1'(c & 1), "tog");
      c++;
    end
    chk("tog_done",  32'(done0), 32'd1);
    chk("tog_total", 32'(pass0) + 32'(fail0), 32'd256);

    // Reset after 10 beats discards the run.
    cyc(1'b1, 1'b0, 8'h00, 4'h0, "start_rst");
    for (int i = 0; i < 10; i++) rand_beat(1'b0, 1'b1, "pre_rst");
    do_reset("mid_reset");
    chk("mid_reset_busy", 32'(busy0), 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 4'h0, "restart");
    chk("restart_pass", 32'(pass0), 32'd0);
    chk("restart_fail", 32'(fail0), 32'd0);
    chk("restart_busy", 32'(busy0), 32'd1);

    // start mid-run is ignored; start in DONE clears and reruns.
    for (int i = 0; i < 5; i++) rand_beat(1'b0, 1'b1, "run6");
    rand_beat(1'b1, 1'b1, "mid_start");
    chk("mid_start_total", 32'(pass0) + 32'(fail0), 32'd6);
    c = 0;
    while (!done0 && c < 600) begin
      rand_beat(1'b0, 1'($urandom_range(0, 1)), "run6");
      c++;
    end
    chk("run6_done", 32'(done0), 32'd1);
    cyc(1'b1, 1'b0, 8'h00, 4'h0, "done_start");
    chk("done_start_pass", 32'(pass0), 32'd0);
    chk("done_start_fail", 32'(fail0), 32'd0);
    chk("done_start_busy", 32'(busy0), 32'd1);
    for (int i = 0; i < 20; i++) rand_beat(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), "tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_pair_checker.md
NOR_PAIR_CHECKER -- requirements
Module: nor_pair_checker

Interface
REQ-001 The module SHALL have parameter NUM_VEC, default 256, meaning the number of accepted beats per run (legal range 1..256).
REQ-002 The module SHALL have parameter CNT_W, default 9, meaning the width of the beat, pass and fail counters.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state changes on its rising edge.
REQ-004 The port reset SHALL be an input, 1 bit wide, asynchronous and active-high.
REQ-005 The port start SHALL be an input, 1 bit wide, and be a run request sampled on clk.
REQ-006 The port in_valid SHALL be an input, 1 bit wide, and mark a beat offered by the upstream NOR bank.
REQ-007 The port in_ready SHALL be an output, 1 bit wide, and indicate that the checker accepts a beat this cycle.
REQ-008 The port in_a SHALL be an input, 8 bits wide, and carry the NOR-bank operands inp_0..inp_7 on in_a[0]..in_a[7].
REQ-009 The port in_s SHALL be an input, 4 bits wide, and carry the NOR-bank outputs out_0..out_3 on in_s[0]..in_s[3].
REQ-010 The port pass_cnt SHALL be an output, CNT_W bits wide, and count the matching beats.
REQ-011 The port fail_cnt SHALL be an output, CNT_W bits wide, and count the mismatching beats.
REQ-012 The port busy SHALL be an output, 1 bit wide, and be high in the RUN state.
REQ-013 The port done SHALL be an output, 1 bit wide, and be high in the DONE state.
REQ-014 The port err SHALL be an output, 1 bit wide, and be high whenever fail_cnt is nonzero.

Function
REQ-015 The expected result SHALL be computed as exp[0]=NOR(a0,a1), exp[1]=NOR(a6,a7), exp[2]=NOR(a4,a5), exp[3]=NOR(a2,a3).
REQ-016 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions:
- IDLE to RUN on start;
- RUN to DONE when the beat that makes beat_cnt equal NUM_VEC is accepted;
- DONE to RUN on start.
REQ-017 On entry to RUN, beat_cnt, pass_cnt and fail_cnt SHALL be cleared in the same edge that changes the state.
REQ-018 The checker SHALL drive in_ready = busy, so no beat is accepted in IDLE or DONE.
REQ-019 A beat SHALL be accepted iff in_valid and in_ready are both high on a rising edge.
REQ-020 An accepted beat SHALL be classified with one-cycle latency: pass_cnt or fail_cnt increments on that edge and is visible the following cycle.
REQ-021 A beat SHALL count as a pass iff in_s equals exp on all four bits.
REQ-022 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 start asserted while in RUN SHALL be ignored.
REQ-024 The last beat SHALL be counted in the same edge that enters DONE.
REQ-025 In DONE, the counters SHALL hold until the next start.
REQ-026 in_a and in_s SHALL be ignored whenever no beat is accepted.

Reset
REQ-027 Reset SHALL force, asynchronously, state=IDLE and beat_cnt=pass_cnt=fail_cnt=0, and therefore in_ready=0, busy=0, done=0, err=0.
REQ-028 A reset asserted mid-run SHALL discard the run; no partial result is retained.

Configuration
REQ-029 With NOR_PAIR_FIRST_ERR_EN defined, the block SHALL add outputs first_err_a[7:0] and first_err_s[3:0], which capture in_a and in_s of the first failing beat of a run, hold until the next start, and reset to 0.
REQ-030 Without NOR_PAIR_FIRST_ERR_EN, those outputs and their registers SHALL be absent.

Structure
REQ-031 The package nor_pair_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and a function nor_pair_expect(a[7:0]) returning the 4-bit value defined in REQ-015.
REQ-032 The saturating counter SHALL be a single sub-module, sat_counter (clear, inc, saturate), instantiated three times.

Verification
REQ-033 A bench SHALL cover these directed scenarios:
- Reset, then 3 idle cycles -> in_ready=0, done=0, both counters 0.
- start, then all 256 values of in_a with the correct in_s -> pass_cnt=256, fail_cnt=0, done=1, err=0.
- NUM_VEC=4: beats a=8'b11011000 with s=4'b0000 (exp: s0=1, so fail), a=0 with s=4'hF, twice a=8'hFF with s=0 -> pass=3, fail=1, err=1; with the macro defined, first_err_a=8'hD8.
- in_valid toggling every other cycle during a run -> only the handshaked beats are counted; done is reached after exactly NUM_VEC accepts.
- reset asserted after 10 beats, then start -> counters begin again from 0.
- start pulsed mid-run -> no counter clear; start in DONE -> counters clear and a new run begins.
